// File: rtl/alchemy_axi_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : alchemy_axi_mmio_bridge
// Brief    : AXI4-Lite slave exposing a RW/RO register bank and an external
//            single-port BRAM, with byte strobes and SLVERR on illegal access.
// Revision : 1.0  initial release
// ============================================================================
module alchemy_axi_mmio_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int RO_BASE  = 16,
  parameter int NUM_RO   = 5,
  parameter int BRAM_AW  = 10,
  parameter int BRAM_LAT = 2
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  input  logic [NUM_RO*DATA_W-1:0]   status_in,
  output logic [NUM_REGS*DATA_W-1:0] ctrl_out,
  output logic                       bram_en,
  output logic [DATA_W/8-1:0]        bram_we,
  output logic [BRAM_AW-1:0]         bram_addr,
  output logic [DATA_W-1:0]          bram_din,
  input  logic [DATA_W-1:0]          bram_dout
);

  localparam int         c_strb_w   = DATA_W / 8;
  localparam int         c_addr_lsb = $clog2(c_strb_w);
  localparam int         c_win_bit  = BRAM_AW + c_addr_lsb;
  localparam logic [6:0] c_num_regs = 7'(NUM_REGS);
  localparam logic [6:0] c_ro_lo    = 7'(RO_BASE);
  localparam logic [6:0] c_ro_hi    = 7'(RO_BASE + NUM_RO);
  localparam logic [1:0] c_lat_m1   = 2'(BRAM_LAT - 1);
  localparam logic [1:0] c_okay     = 2'b00;
  localparam logic [1:0] c_slverr   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ACK  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ACK  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_RESP = 3'd5
  } state_t;

  state_t                r_state, w_next;
  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic                  r_last_rd, r_is_reg;
  logic [5:0]            r_idx;
  logic [DATA_W-1:0]     r_wdata, r_rdata, r_bram_din;
  logic [c_strb_w-1:0]   r_wstrb, r_bram_we;
  logic [1:0]            r_cnt, r_bresp, r_rresp;
  logic                  r_bram_en;
  logic [BRAM_AW-1:0]    r_bram_addr;

  logic                  w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd;
  logic [ADDR_W-1:0]     w_gaddr;
  logic                  w_idx_ok, w_idx_rw, w_reg_we;
  logic [DATA_W-1:0]     w_reg_rd;
  logic                  w_unused;

  // On contention the kind not granted last wins; r_last_rd resets to READ.
  assign w_wr_pend  = S_AXI_AWVALID && S_AXI_WVALID;
  assign w_rd_pend  = S_AXI_ARVALID;
  assign w_grant_wr = (r_state == S_IDLE) && w_wr_pend && (!w_rd_pend || r_last_rd);
  assign w_grant_rd = (r_state == S_IDLE) && w_rd_pend && !w_grant_wr;
  assign w_gaddr    = w_grant_wr ? S_AXI_AWADDR : S_AXI_ARADDR;

  assign w_idx_ok = ({1'b0, r_idx} < c_num_regs);
  assign w_idx_rw = w_idx_ok && !(({1'b0, r_idx} >= c_ro_lo) && ({1'b0, r_idx} < c_ro_hi));
  assign w_reg_we = (r_state == S_WR_ACK) && r_is_reg && w_idx_rw;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_gaddr};

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_wr)      w_next = S_WR_ACK;
        else if (w_grant_rd) w_next = S_RD_ACK;
      end
      S_WR_ACK:  w_next = S_WR_RESP;
      S_WR_RESP: if (S_AXI_BREADY) w_next = S_IDLE;
      S_RD_ACK:  w_next = r_is_reg ? S_RD_RESP : S_RD_WAIT;
      S_RD_WAIT: if (r_cnt == 2'd0) w_next = S_RD_RESP;
      S_RD_RESP: if (S_AXI_RREADY) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // BRAM strobes are registered at grant so they land exactly in the ACK cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_last_rd   <= 1'b1;
      r_is_reg    <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_cnt       <= '0;
      r_bresp     <= c_okay;
      r_rresp     <= c_okay;
      r_rdata     <= '0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      r_bram_en <= 1'b0;
      r_bram_we <= '0;
      if (w_grant_wr || w_grant_rd) begin
        r_last_rd <= w_grant_rd;
        r_is_reg  <= w_gaddr[c_win_bit];
        r_idx     <= w_gaddr[c_addr_lsb +: 6];
        if (w_grant_wr) begin
          r_wdata <= S_AXI_WDATA;
          r_wstrb <= S_AXI_WSTRB;
        end
        if (!w_gaddr[c_win_bit]) begin
          r_bram_en   <= 1'b1;
          r_bram_addr <= w_gaddr[c_addr_lsb +: BRAM_AW];
          if (w_grant_wr) begin
            r_bram_we  <= S_AXI_WSTRB;
            r_bram_din <= S_AXI_WDATA;
          end
        end
      end
      case (r_state)
        S_WR_ACK: r_bresp <= (r_is_reg && !w_idx_rw) ? c_slverr : c_okay;
        S_RD_ACK: begin
          if (r_is_reg) begin
            r_rdata <= w_idx_ok ? w_reg_rd : '0;
            r_rresp <= w_idx_ok ? c_okay : c_slverr;
          end else begin
            r_cnt   <= c_lat_m1;
            r_rresp <= c_okay;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == 2'd0) r_rdata <= bram_dout;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_reg_we && (r_idx == 6'(i)))
          for (int b = 0; b < c_strb_w; b++)
            if (r_wstrb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
      for (int k = 0; k < NUM_RO; k++)
        r_regs[RO_BASE+k] <= status_in[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_reg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (r_idx == 6'(i)) w_reg_rd = r_regs[i];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_ctrl
    assign ctrl_out[i*DATA_W +: DATA_W] = r_regs[i];
  end

  assign S_AXI_AWREADY = (r_state == S_WR_ACK);
  assign S_AXI_WREADY  = (r_state == S_WR_ACK);
  assign S_AXI_BVALID  = (r_state == S_WR_RESP);
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = (r_state == S_RD_ACK);
  assign S_AXI_RVALID  = (r_state == S_RD_RESP);
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign bram_en       = r_bram_en;
  assign bram_we       = r_bram_we;
  assign bram_addr     = r_bram_addr;
  assign bram_din      = r_bram_din;

endmodule
`default_nettype wire

// File: tb/tb_alchemy_axi_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_alchemy_axi_mmio_bridge
// Brief    : Self-checking bench: fixed vector table, random traffic against a
//            spec-level model, plus arbitration and reset corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_alchemy_axi_mmio_bridge;

  localparam int NREG = 24;
  localparam int NRO  = 5;
  localparam int ROB  = 16;
  localparam int LAT  = 2;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic [15:0]        AWADDR = '0, ARADDR = '0;
  logic [2:0]         AWPROT = '0, ARPROT = '0;
  logic               AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [31:0]        WDATA = '0;
  logic [3:0]         WSTRB = '0;
  logic               AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]         BRESP, RRESP;
  logic [31:0]        RDATA;
  logic [NRO*32-1:0]  status_in = '0;
  logic [NREG*32-1:0] ctrl_out;
  logic               bram_en;
  logic [3:0]         bram_we;
  logic [9:0]         bram_addr;
  logic [31:0]        bram_din;
  logic [31:0]        bram_dout = '0;

  always #5 clk = ~clk;

  alchemy_axi_mmio_bridge #(
    .DATA_W(32), .ADDR_W(16), .NUM_REGS(NREG), .RO_BASE(ROB), .NUM_RO(NRO),
    .BRAM_AW(10), .BRAM_LAT(LAT)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .status_in(status_in), .ctrl_out(ctrl_out),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  // BRAM stand-in with two cycles from enable to valid read data.
  logic [31:0] bram_mem [1024] = '{default: 32'h0};
  logic [31:0] rd_pipe = '0;
  logic        preload_done = 1'b0;
  always @(posedge clk) begin
    if (!preload_done) begin
      bram_mem[5]  <= 32'h1100_2200;
      preload_done <= 1'b1;
    end else if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bram_mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
      rd_pipe <= bram_mem[bram_addr];
    end
    bram_dout <= rd_pipe;
  end

  // Reference model: register file, BRAM image and status words.
  logic [31:0] ref_regs [NREG];
  logic [31:0] ref_mem [1024] = '{default: 32'h0};
  logic [31:0] ref_status [NRO];

  function automatic logic [1:0] ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[7:2]);
    int w   = int'(a[11:2]);
    if (a[12]) begin
      if (idx >= NREG || (idx >= ROB && idx < ROB + NRO)) return 2'b10;
      for (int b = 0; b < 4; b++) if (s[b]) ref_regs[idx][b*8 +: 8] = d[b*8 +: 8];
      return 2'b00;
    end
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  task automatic ref_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a[7:2]);
    r = 2'b00;
    if (!a[12])                           d = ref_mem[int'(a[11:2])];
    else if (idx >= NREG) begin           d = 32'h0; r = 2'b10; end
    else if (idx >= ROB && idx < ROB+NRO) d = ref_status[idx - ROB];
    else                                  d = ref_regs[idx];
  endtask

  task automatic set_status(input int k, input logic [31:0] v);
    ref_status[k] = v;
    status_in[k*32 +: 32] = v;
  endtask

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        g_en;
  logic [3:0]  g_we;
  logic [9:0]  g_addr;
  logic [31:0] g_din;

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int rdy_cyc, output int b_cyc);
    bit acc;
    acc = 0; resp = 2'b11; rdy_cyc = -1; b_cyc = -1;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (acc) begin AWVALID = 0; WVALID = 0; end
      if (AWREADY && WREADY && !acc) begin
        acc = 1; rdy_cyc = c;
        g_en = bram_en; g_we = bram_we; g_addr = bram_addr; g_din = bram_din;
      end
      if (BVALID) begin b_cyc = c; resp = BRESP; break; end
    end
    AWVALID = 0; WVALID = 0;
    @(posedge clk); #1;
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [15:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] resp, output int r_cyc);
    bit acc;
    acc = 0; d = '0; resp = 2'b11; r_cyc = -1;
    ARADDR = a; ARVALID = 1; RREADY = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (acc) ARVALID = 0;
      if (ARREADY) acc = 1;
      if (RVALID) begin r_cyc = c; d = RDATA; resp = RRESP; break; end
    end
    ARVALID = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("rd_hold_stable", {RVALID, RRESP, RDATA}, {1'b1, resp, d});
    end
    RREADY = 1;
    @(posedge clk); #1;
    RREADY = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  eresp;
    logic [31:0] edata;
    int          ecyc;
    int          hold;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [15:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] er, logic [31:0] ed, int ec, int h);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.eresp = er; v.edata = ed; v.ecyc = ec; v.hold = h;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] resp; logic [31:0] d; int rc, bc;
    if (v.wr) begin
      axi_write(v.addr, v.data, v.strb, resp, rc, bc);
      chk({tag, "_bresp"}, resp, v.eresp);
      chk({tag, "_wready_cyc"}, rc, 1);
      chk({tag, "_bvalid_cyc"}, bc, v.ecyc);
      if (!v.addr[12])
        chk({tag, "_bram_wr"}, {g_en, g_we, g_addr, g_din}, {1'b1, v.strb, v.addr[11:2], v.data});
    end else begin
      axi_read(v.addr, v.hold, d, resp, rc);
      chk({tag, "_rresp"}, resp, v.eresp);
      chk({tag, "_rdata"}, d, v.edata);
      chk({tag, "_rvalid_cyc"}, rc, v.ecyc);
    end
  endtask

  vec_t tbl[12];

  initial begin
    logic [31:0] d; logic [1:0] r;
    vec_t v;
    tbl[0]  = mk(1, 16'h1054, 32'h0000_0123, 4'hF, 2'b00, 32'h0,         2,     0);
    tbl[1]  = mk(0, 16'h1054, 32'h0,         4'h0, 2'b00, 32'h0000_0123, 2,     0);
    tbl[2]  = mk(1, 16'h0014, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0,         2,     0);
    tbl[3]  = mk(0, 16'h0014, 32'h0,         4'h0, 2'b00, 32'h11BB_22DD, 2+LAT, 2);
    tbl[4]  = mk(1, 16'h1040, 32'h0000_0055, 4'hF, 2'b10, 32'h0,         2,     0);
    tbl[5]  = mk(0, 16'h1040, 32'h0,         4'h0, 2'b00, 32'h0000_0077, 2,     0);
    tbl[6]  = mk(0, 16'h1078, 32'h0,         4'h0, 2'b10, 32'h0,         2,     1);
    tbl[7]  = mk(1, 16'h1078, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0,         2,     0);
    tbl[8]  = mk(1, 16'h1008, 32'hDEAD_BEEF, 4'h3, 2'b00, 32'h0,         2,     0);
    tbl[9]  = mk(0, 16'h100B, 32'h0,         4'h0, 2'b00, 32'h0000_BEEF, 2,     0);
    tbl[10] = mk(0, 16'h1050, 32'h0,         4'h0, 2'b00, 32'h4444_4444, 2,     0);
    tbl[11] = mk(0, 16'h1057, 32'h0,         4'h0, 2'b00, 32'h0000_0123, 2,     0);

    for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
    ref_mem[5] = 32'h1100_2200;
    set_status(0, 32'h77);
    for (int k = 1; k < NRO; k++) set_status(k, {4{8'(k * 8'h11)}});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_handshake", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
    chk("rst_resp_data", {BRESP, RRESP, RDATA}, 36'h0);
    chk("rst_bram", {bram_en, bram_we, bram_addr, bram_din}, 47'h0);
    chk("rst_ctrl_out", (ctrl_out == '0), 1'b1);
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) void'(ref_write(tbl[i].addr, tbl[i].data, tbl[i].strb));
      else           ref_read(tbl[i].addr, d, r);
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end
    chk("ctrl_reg21", ctrl_out[21*32 +: 32], 32'h123);
    chk("ctrl_reg16_ro", ctrl_out[16*32 +: 32], 32'h77);
    chk("ctrl_reg2_strb", ctrl_out[2*32 +: 32], 32'h0000_BEEF);

    // Random traffic against the model
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) set_status(int'($urandom_range(0, NRO-1)), $urandom);
      v.wr   = 1'($urandom_range(0, 1));
      v.addr = $urandom_range(0, 1) ? (16'h1000 | 16'($urandom_range(0, 31) << 2))
                                    : 16'($urandom_range(0, 15) << 2);
      v.addr[1:0] = 2'($urandom_range(0, 3));
      v.data = $urandom;
      v.strb = 4'($urandom_range(0, 15));
      v.hold = int'($urandom_range(0, 2));
      if (v.wr) begin
        v.eresp = ref_write(v.addr, v.data, v.strb); v.edata = '0; v.ecyc = 2;
      end else begin
        ref_read(v.addr, d, r);
        v.eresp = r; v.edata = d; v.ecyc = v.addr[12] ? 2 : 2 + LAT;
      end
      run_vec(v, "rnd");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < NREG; i++)
      chk($sformatf("rnd_ctrl_reg%0d", i), ctrl_out[i*32 +: 32],
          (i >= ROB && i < ROB + NRO) ? ref_status[i - ROB] : ref_regs[i]);

    // Arbitration: first contention goes to the write, the next to the read
    rst_n = 0; @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
    chk("rst_rw_reg21", ctrl_out[21*32 +: 32], 32'h0);
    AWADDR = 16'h100C; WDATA = 32'hA5; WSTRB = 4'hF; ARADDR = 16'h1054;
    AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 1; RREADY = 1;
    @(posedge clk); #1;
    chk("arb1_write_first", {AWREADY, ARREADY}, 2'b10);
    @(posedge clk); #1;
    chk("arb1_bvalid", {BVALID, BRESP}, 3'b100);
    AWADDR = 16'h1010; WDATA = 32'h5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arb2_read_second", {AWREADY, ARREADY}, 2'b01);
    @(posedge clk); #1;
    ARVALID = 0; AWVALID = 0; WVALID = 0;
    chk("arb2_rvalid", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, 32'h0});
    @(posedge clk); #1;
    RREADY = 0; BREADY = 0;
    void'(ref_write(16'h100C, 32'hA5, 4'hF));
    run_vec(mk(1, 16'h1010, 32'h5A, 4'hF, ref_write(16'h1010, 32'h5A, 4'hF), 32'h0, 2, 0), "arb_w2");
    chk("arb_ctrl_reg3", ctrl_out[3*32 +: 32], 32'hA5);
    chk("arb_ctrl_reg4", ctrl_out[4*32 +: 32], 32'h5A);

    // Asynchronous reset in the middle of a BRAM read
    ARADDR = 16'h0014; ARVALID = 1; RREADY = 0;
    @(posedge clk); #1;
    chk("rdw_ack", {ARREADY, bram_en, bram_we}, {1'b1, 1'b1, 4'h0});
    @(posedge clk); #1;
    ARVALID = 0;
    rst_n = 0;
    #1;
    chk("rdw_rst_outputs", {RVALID, bram_en, ARREADY, RDATA}, 35'h0);
    chk("rdw_rst_reg3", ctrl_out[3*32 +: 32], 32'h0);
    chk("rdw_rst_reg4", ctrl_out[4*32 +: 32], 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
    ref_read(16'h100C, d, r);
    run_vec(mk(0, 16'h100C, 32'h0, 4'h0, r, d, 2, 0), "post_rst_reg");
    ref_read(16'h0014, d, r);
    run_vec(mk(0, 16'h0014, 32'h0, 4'h0, r, d, 2 + LAT, 0), "post_rst_bram");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alchemy_axi_mmio_bridge.md
Name: alchemy_axi_mmio_bridge

Overview:
Parametrised AXI4-Lite slave bridging the MicroBlaze bus to two windows: a register bank (RW control plus RO status) and an external single-port BRAM.
It generalises the fixed 32-register / 2-cycle controller:
- configurable register count, RO status slice, BRAM depth and BRAM read latency;
- byte strobes honoured on both windows;
- SLVERR on illegal access;
- fair write/read arbitration.

It sits between the AXI interconnect and the game renderer / menu logic.

Parameters:
DATA_W, 32, bus and register width (32 or 64); ADDR_LSB = log2(DATA_W/8)
ADDR_W, 16, AXI address width; must be >= BRAM_AW+ADDR_LSB+1
NUM_REGS, 32, registers in register window (1..64)
RO_BASE, 16, index of first read-only status register
NUM_RO, 5, number of read-only status registers; RO_BASE+NUM_RO <= NUM_REGS
BRAM_AW, 10, BRAM word-address width
BRAM_LAT, 2, cycles from bram_en to valid bram_dout (1..4)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite, widths ADDR_W/DATA_W; PROT ignored
status_in  in  NUM_RO*DATA_W  RO status words; slice k maps to register RO_BASE+k
ctrl_out  out  NUM_REGS*DATA_W  flat view of all registers; slice i = register i
bram_en  out  1  BRAM port enable
bram_we  out  DATA_W/8  byte write enables
bram_addr  out  BRAM_AW  word address
bram_din  out  DATA_W  write data
bram_dout  in  DATA_W  read data

Behaviour:
Address decode:
- Window select bit = AWADDR/ARADDR[BRAM_AW+ADDR_LSB]: 1 = registers, 0 = BRAM.
- Register index = addr[ADDR_LSB+5:ADDR_LSB].
- BRAM word = addr[ADDR_LSB+BRAM_AW-1:ADDR_LSB].
- Low ADDR_LSB bits are ignored.

Reset (async assert, sync deassert handled upstream):
- FSM goes to IDLE. All READY/VALID low; BRESP, RRESP, RDATA = 0.
- bram_en/we = 0, bram_addr/din = 0. All RW registers = 0. last_grant = READ.
- Any in-flight transaction is dropped. A BRAM write is never half-issued, because bram_we is registered.

RO registers:
- Each cycle, reg[RO_BASE+k] <= status_in slice k.
- ctrl_out reflects these sampled values.

FSM states: IDLE, WR_ACK, WR_RESP, RD_ACK, RD_WAIT, RD_RESP.

IDLE:
- Write pending = AWVALID&&WVALID. Read pending = ARVALID.
- If both are pending, grant the kind not granted last, then toggle last_grant.
- Grant write: latch AWADDR, WDATA, WSTRB; go to WR_ACK.
- Grant read: latch ARADDR; go to RD_ACK.

WR_ACK (1 cycle):
- AWREADY=WREADY=1.
- Register window with index < NUM_REGS and not RO: bytes with WSTRB=1 are updated at cycle end.
- RO index or index >= NUM_REGS: no update, error flag set.
- BRAM window: bram_en=1, bram_we=WSTRB, bram_addr, bram_din driven this cycle.
- Go to WR_RESP.

WR_RESP:
- BVALID=1; BRESP = 2'b10 if error flag set, else 2'b00.
- Held until BREADY, then IDLE.

RD_ACK (1 cycle):
- ARREADY=1.
- BRAM window: bram_en=1, bram_addr driven, bram_we=0; load counter = BRAM_LAT-1; go to RD_WAIT.
- Register window: capture reg[index] (0 with SLVERR if index >= NUM_REGS) into RDATA; go to RD_RESP.

RD_WAIT:
- Decrement counter each cycle.
- When the counter reaches 0, capture bram_dout into RDATA and go to RD_RESP.

RD_RESP:
- RVALID=1; RDATA and RRESP stable until RREADY, then IDLE.

Latency (VALID seen in cycle 0):
- Write: READYs in cycle 1, BVALID in cycle 2.
- Register read: ARREADY in cycle 1, RVALID in cycle 2.
- BRAM read: RVALID in cycle 2+BRAM_LAT.

Handshake rules:
- Only one outstanding transaction; no READY is asserted outside the ACK states.
- AW without W (or W without AW) waits in IDLE. The bridge never accepts one channel alone.

Test Plan:
- Write 0x0000_0123 to register 21 (addr 0x1054), then read it back -> BVALID cycle 2, BRESP=0; RDATA=0x123 at RVALID cycle 2; ctrl_out slice 21 = 0x123.
- Write 0xAABBCCDD with WSTRB=0b0101 to BRAM word 5 -> bram_we=0101, bram_addr=5 in cycle 1. Read word 5 with BRAM_LAT=2 and model returning 0x11BB22DD -> RVALID cycle 4, RDATA=0x11BB22DD.
- Drive status_in slice 0 = 0x77; write 0x55 to register 16 -> BRESP=2'b10, no register change; read of register 16 returns 0x77, RRESP=0.
- With NUM_REGS=24, read register 30 -> RDATA=0, RRESP=2'b10.
- Assert AWVALID+WVALID+ARVALID together twice in a row -> first grant is the write, second is the read.
- Assert reset during RD_WAIT -> RVALID=0 and bram_en=0 immediately; FSM returns to IDLE; RW registers = 0.
